// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t            FSM encoding: IDLE -> RUN -> FINISH -> IDLE
//   DIV_WIDTH          default operand/result width
//   DIV_ZERO_QUOTIENT  quotient reported when the divisor is zero
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

endpackage : seq_divider_pkg

// File: rtl/seq_divider_sub_step.sv
// One restoring-division iteration, purely combinational.
// Ports:
//   rem       in   WIDTH  current partial remainder
//   shift_in  in   1      next dividend bit (MSB of the quotient shift register)
//   divisor   in   WIDTH  divisor magnitude
//   rem_next  out  WIDTH  partial remainder after this step
//   q_bit     out  1      quotient bit produced by this step
module seq_divider_sub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The shifted remainder can reach WIDTH+1 bits, so the subtract is one bit
  // wider than the operands; bit WIDTH of the result is the borrow.
  assign shifted  = {rem, shift_in};
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[WIDTH];
  // On a borrow the shifted value is below the divisor, so its top bit is 0
  // and dropping it loses nothing.
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule : seq_divider_sub_step

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (DIV/DIVU -> HI/LO).
// One trial subtraction per cycle, WIDTH iterations, then a sign fix-up cycle.
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset
//   start        in   1      request a division (honoured only when idle)
//   div_signed   in   1      1 = signed (DIV), 0 = unsigned (DIVU)
//   dividend     in   WIDTH  sampled with start
//   divisor      in   WIDTH  sampled with start
//   busy         out  1      division in progress
//   done         out  1      one-cycle pulse, results valid in that cycle
//   quotient     out  WIDTH  LO result, held until the next completion
//   remainder    out  WIDTH  HI result, held until the next completion
//   div_by_zero  out  1      divisor was zero, held with the results
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   rem_q;      // partial remainder
  logic [WIDTH-1:0]   quo_q;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   divisor_q;  // divisor magnitude
  logic               neg_quot;
  logic               neg_rem;
  logic               zero_div_q;

  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;

  logic               dividend_neg;
  logic               divisor_neg;

  assign dividend_neg = div_signed & dividend[WIDTH-1];
  assign divisor_neg  = div_signed & divisor[WIDTH-1];

  seq_divider_sub_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .shift_in (quo_q[WIDTH-1]),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (start) state_next = ST_RUN;
      ST_RUN:    if (count == LAST_COUNT) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      neg_quot    <= 1'b0;
      neg_rem     <= 1'b0;
      zero_div_q  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            // The magnitude of the most negative value is itself when read
            // as unsigned, so no extra width is needed.
            quo_q      <= dividend_neg ? -dividend : dividend;
            divisor_q  <= divisor_neg  ? -divisor  : divisor;
            neg_quot   <= dividend_neg ^ divisor_neg;
            neg_rem    <= dividend_neg;
            zero_div_q <= (divisor == '0);
            rem_q      <= '0;
            count      <= '0;
            busy       <= 1'b1;
          end
        end
        ST_RUN: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[WIDTH-2:0], q_bit};
          count <= count + 1'b1;
        end
        ST_FINISH: begin
          // With a zero divisor every step subtracts nothing, so rem_q ends up
          // as the dividend magnitude and the sign fix-up restores the raw
          // dividend; only the quotient needs overriding.
          if (zero_div_q)    quotient <= WIDTH'(DIV_ZERO_QUOTIENT);
          else if (neg_quot) quotient <= -quo_q;
          else               quotient <= quo_q;
          remainder   <= neg_rem ? -rem_q : rem_q;
          div_by_zero <= zero_div_q;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random
// operands, checked by a scoreboard fed from an arithmetic reference model.
module tb_seq_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  logic        prev_done = 1'b0;

  seq_divider dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics via plain integer arithmetic.
  function automatic exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa;
    int   sb_v;
    e.dz  = 1'b0;
    e.cyc = 0;
    if (b == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = 32'd0;
      end else begin
        sa   = a;
        sb_v = b;
        e.q  = sa / sb_v;
        e.r  = sa % sb_v;
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Issue one division at a falling edge once the divider is free; returns at
  // the following falling edge with start low again.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int   n;
    exp_t e;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_timeout", {31'd0, busy}, 32'd0);
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    start      = 1'b1;
    e          = model(sgn, a, b);
    e.cyc      = cyc + 34;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: compares every done pulse against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      check("done_width", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        check("latency", cyc, e.cyc);
        check("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
    prev_done = done;
  end

  initial begin
    int          n;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;

    rst        = 1'b1;
    start      = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic DIVU, with busy observed mid-run.
    do_div(1'b0, 32'd100, 32'd7);
    check("busy_start", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    check("busy_mid", {31'd0, busy}, 32'd1);

    // Signed sign rules, overflow wrap, unsigned view of the same operands.
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div(1'b0, 32'd5, 32'd0);
    do_div(1'b1, 32'hFFFF_FFF0, 32'd0);

    // A start during a run is ignored; the next start lands in the done cycle.
    do_div(1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    div_signed = 1'b0;
    dividend   = 32'd10;
    divisor    = 32'd3;
    start      = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    do_div(1'b0, 32'd10, 32'd3);

    // Reset mid-run: outputs clear at once and the abandoned op never completes.
    do_div(1'b0, 32'd100, 32'd7);
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);
    check("midrst_dz", {31'd0, div_by_zero}, 32'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_done_busy", {31'd0, busy}, 32'd0);
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7);

    // Random operands with a bias toward the interesting divisors.
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        3:       b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      do_div(sgn, a, b);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drained", sb.size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_divider
